// File: rtl/multi_seq_detector.sv
`default_nettype none
// ============================================================================
// Module   : multi_seq_detector
// Purpose  : Moore-type serial pattern detector. Compares the last PAT_LEN
//            accepted bits of a valid-qualified serial stream against NUM_PAT
//            programmable patterns. Overlapping or non-overlapping detection
//            can be selected at runtime. A saturating counter tracks hits.
// Ports    : clk        - rising-edge clock
//            reset      - synchronous, active-high reset
//            in_valid   - bit_in is accepted on an edge when high
//            bit_in     - serial data bit
//            overlap_en - 1 = overlapping, 0 = restart after each match
//            cnt_clear  - synchronous clear of hit_count (wins over a hit)
//            match_vec  - registered per-pattern completion flags
//            detect     - registered OR of match_vec
//            hit_count  - saturating count of detect pulses
// Revision : 1.0 - initial release
// ============================================================================
module multi_seq_detector #(
  parameter int                           PAT_LEN  = 3,
  parameter int                           NUM_PAT  = 2,
  parameter logic [NUM_PAT*PAT_LEN-1:0]   PATTERNS = {3'b110, 3'b101},
  parameter int                           CNT_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               bit_in,
  input  logic               overlap_en,
  input  logic               cnt_clear,
  output logic [NUM_PAT-1:0] match_vec,
  output logic               detect,
  output logic [CNT_W-1:0]   hit_count
);

  localparam int             FW     = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0]  C_FULL = FW'(PAT_LEN);

  // Only the newest PAT_LEN-1 bits are kept: the oldest bit of the compare
  // window would be shifted out on the same edge that it is compared, so it
  // never needs to be stored.
  logic [PAT_LEN-2:0] r_hist;
  logic [FW-1:0]      r_fill;
  logic [NUM_PAT-1:0] r_match;
  logic               r_detect;
  logic [CNT_W-1:0]   r_cnt;

  logic [PAT_LEN-1:0] w_nh;
  logic [FW-1:0]      w_nf;
  logic               w_full;
  logic [NUM_PAT-1:0] w_m;
  logic               w_any;

  assign w_nh   = {r_hist, bit_in};
  assign w_nf   = (r_fill == C_FULL) ? r_fill : r_fill + 1'b1;
  // The fill gate keeps reset zeros in the history from aliasing a pattern.
  assign w_full = (w_nf == C_FULL);

  generate
    for (genvar gi = 0; gi < NUM_PAT; gi++) begin : g_pat
      assign w_m[gi] = w_full && (w_nh == PATTERNS[gi*PAT_LEN +: PAT_LEN]);
    end
  endgenerate

  assign w_any = |w_m;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hist   <= '0;
      r_fill   <= '0;
      r_match  <= '0;
      r_detect <= 1'b0;
    end else if (in_valid) begin
      r_match  <= w_m;
      r_detect <= w_any;
      if (w_any && !overlap_en) begin
        // Non-overlapping: the next match needs PAT_LEN fresh bits.
        r_hist <= '0;
        r_fill <= '0;
      end else begin
        r_hist <= w_nh[PAT_LEN-2:0];
        r_fill <= w_nf;
      end
    end else begin
      r_match  <= '0;
      r_detect <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (cnt_clear) begin
      r_cnt <= '0;
    end else if (in_valid && w_any && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign match_vec = r_match;
  assign detect    = r_detect;
  assign hit_count = r_cnt;

endmodule
`default_nettype wire

// File: doc/multi_seq_detector.md
Name: multi_seq_detector

Overview:
- Parametrised Moore-type serial pattern detector. Successor to the fixed 110/101 detectors.
- Watches a 1-bit serial stream qualified by a valid strobe and compares the last PAT_LEN accepted bits against NUM_PAT programmable patterns.
- Overlapping versus non-overlapping detection is selectable at runtime.
- Provides per-pattern match flags, an any-match pulse and a saturating hit counter.
- Sits between a serial input front-end and the status/LED logic of the lab designs.

Parameters:
- PAT_LEN, 3: bits per pattern (2..16).
- NUM_PAT, 2: number of patterns (1..8).
- PATTERNS, {3'b110, 3'b101}: NUM_PAT*PAT_LEN bits. Pattern i is PATTERNS[i*PAT_LEN +: PAT_LEN]; the pattern MSB is the earliest bit received.
- CNT_W, 8: hit counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  bit_in is accepted on a rising edge when in_valid=1.
- bit_in  in  1  serial data bit.
- overlap_en  in  1  1 = overlapping detection, 0 = non-overlapping.
- cnt_clear  in  1  synchronous clear of hit_count.
- match_vec  out  NUM_PAT  registered; bit i = pattern i completed by the last accepted bit.
- detect  out  1  registered; OR of match_vec.
- hit_count  out  CNT_W  number of detect pulses, saturating.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high: on a rising edge with reset=1, all state clears and all outputs go to 0. Reset overrides every other input, including mid-sequence; any partial sequence is discarded.
- State:
  - hist[PAT_LEN-1:0]: shift register; a new bit enters the LSB and older bits shift toward the MSB.
  - fill: counts 0..PAT_LEN, saturates at PAT_LEN.
  - Registered outputs.
- Accept edge (in_valid=1, reset=0):
  - nh = {hist[PAT_LEN-2:0], bit_in}; nf = min(fill+1, PAT_LEN).
  - m[i] = (nf==PAT_LEN) && (nh == pattern i).
  - match_vec <= m; detect <= |m.
  - If |m and overlap_en=0: hist <= 0 and fill <= 0, so the next match needs PAT_LEN fresh bits.
  - Otherwise: hist <= nh and fill <= nf.
- Non-accept edge (in_valid=0): hist and fill hold; match_vec and detect go to 0.
- Output timing: outputs are one-cycle pulses, visible in the cycle after the edge that accepted the completing bit (latency 1 clk). Back-to-back completing bits give back-to-back pulses.
- Matching rules:
  - No match is possible until PAT_LEN bits have been accepted since reset or since a non-overlap restart. Zeros left in hist from reset never alias to a pattern.
  - Multiple patterns may match on the same bit: all corresponding match_vec bits are set, and the event counts as one detect.
  - Duplicate patterns are legal; both bits are set.
- overlap_en: sampled on each accept edge. Changing it mid-stream affects only the restart decision at that edge.
- hit_count:
  - If cnt_clear=1: hit_count <= 0. Clear wins over a simultaneous hit; that hit is not counted, but match_vec and detect still pulse.
  - Else if the edge produces detect=1 and hit_count != all-ones: hit_count <= hit_count+1.
  - The count saturates at 2^CNT_W-1 and never wraps.
- cnt_clear does not affect hist, fill or overlap.
- Structure: no combinational path from inputs to outputs; all outputs come directly from flops (Moore).

Test Plan:
1. Reset, overlap_en=1, accept bits 1,1,0,1. Required: match_vec=2'b10 after bit 3 (110) and 2'b01 after bit 4 (101); detect pulses twice; hit_count=2.
2. overlap_en=1, bits 1,0,1,0,1. Required: 101 detected after bits 3 and 5; hit_count=2. Repeat with overlap_en=0: detect only after bit 3 (bits 4-5 give fill=2 < 3); hit_count=1.
3. Accept 1,1, assert reset for one edge, then accept 0. Required: no detect (fill=1); all outputs 0 during and after reset.
4. Bits 1,1,0 with in_valid=0 gaps of 0-3 cycles between them. Required: the result equals the gapless case (one detect, match_vec=2'b10); outputs are 0 during gaps; the pulse lasts one cycle.
5. CNT_W=2, stream 1,0,1,0,1,0,1,0,1 with overlap. Required: 4 detects, hit_count saturates at 3. Then cnt_clear coincident with a completing bit: detect=1 and hit_count=0.
6. PAT_LEN=4, NUM_PAT=3, PATTERNS={4'b1011, 4'b1011, 4'b0000}. Required: after reset, bits 0,0,0 give no match; a fourth 0 gives match_vec=3'b001. Bits 1,0,1,1 give match_vec=3'b110 and hit_count +1.
